instrmem_loader: RTL and testbench

Boot-time writer for the instruction memory. Accepts a framed byte stream over a valid/ready handshake (4-byte little-endian length, payload, 1-byte XOR checksum) and writes each payload byte into the byte-addressed instruction memory starting at 0xBFC00000. It holds the CPU in reset until a clean load completes. It sits between the host link (UART receiver or testbench) and the memory write port.

---
 rtl/instrmem_pkg.sv | 17 +
 rtl/instrmem_loader.sv | 133 +++++++++++++
 tb/tb_instrmem_loader.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instrmem_pkg.sv
// Shared definitions for the boot-time instruction memory loader and the
// instruction memory it fills.
package instrmem_pkg;

  localparam logic [31:0] BASE_ADDR = 32'hBFC0_0000;
  localparam int          MEM_BYTES = 4096;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_LOAD,
    ST_CHK,
    ST_DONE,
    ST_ERR
  } state_e;

endpackage

// File: rtl/instrmem_loader.sv
// Framed byte-stream loader: 4-byte LE length, payload, XOR checksum.
// Writes payload into instruction memory and holds the CPU in reset until a clean load.
module instrmem_loader #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = instrmem_pkg::BASE_ADDR,
  parameter int                    MEM_BYTES  = instrmem_pkg::MEM_BYTES
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [DATA_WIDTH-1:0] byte_i,
  input  logic                  byte_valid_i,
  output logic                  byte_ready_o,
  output logic                  we_o,
  output logic [ADDR_WIDTH-1:0] waddr_o,
  output logic [DATA_WIDTH-1:0] wdata_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic                  cpu_rst_o
);
  import instrmem_pkg::*;

  // Count is one bit wider than the address range so it can hold MEM_BYTES itself.
  localparam int CW = $clog2(MEM_BYTES) + 1;

  state_e                  state_q, state_d;
  logic [31:0]             len_q;
  logic [31:0]             hdr_len;
  logic [1:0]              hdr_idx_q;
  logic [CW-1:0]           cnt_q;
  logic [CW-1:0]           cnt_nxt;
  logic [DATA_WIDTH-1:0]   csum_q;
  logic                    we_q;
  logic [ADDR_WIDTH-1:0]   waddr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    acc;
  logic                    can_start;

  // Header arrives LSB first, so each new byte shifts in from the top.
  assign hdr_len   = {byte_i, len_q[31:DATA_WIDTH]};
  assign cnt_nxt   = cnt_q + 1'b1;
  assign acc       = byte_valid_i && byte_ready_o;
  assign can_start = start_i && (state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_ERR);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    byte_ready_o = 1'b0;
    busy_o       = 1'b0;
    done_o       = 1'b0;
    err_o        = 1'b0;
    cpu_rst_o    = 1'b1;
    case (state_q)
      ST_IDLE: if (start_i) state_d = ST_HDR;
      ST_HDR: begin
        byte_ready_o = 1'b1;
        busy_o       = 1'b1;
        if (byte_valid_i && hdr_idx_q == 2'd3) begin
          if (hdr_len == 32'd0)                 state_d = ST_CHK;
          else if (hdr_len > 32'(MEM_BYTES))    state_d = ST_ERR;
          else                                  state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        byte_ready_o = 1'b1;
        busy_o       = 1'b1;
        // len_q never exceeds MEM_BYTES here, so its low CW bits are exact.
        if (byte_valid_i && cnt_nxt == len_q[CW-1:0]) state_d = ST_CHK;
      end
      ST_CHK: begin
        byte_ready_o = 1'b1;
        busy_o       = 1'b1;
        if (byte_valid_i) state_d = (byte_i == csum_q) ? ST_DONE : ST_ERR;
      end
      ST_DONE: begin
        done_o    = 1'b1;
        cpu_rst_o = 1'b0;
        if (start_i) state_d = ST_HDR;
      end
      ST_ERR: begin
        err_o = 1'b1;
        if (start_i) state_d = ST_HDR;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      len_q     <= '0;
      hdr_idx_q <= '0;
      cnt_q     <= '0;
      csum_q    <= '0;
      we_q      <= 1'b0;
      waddr_q   <= BASE_ADDR;
      wdata_q   <= '0;
    end else begin
      we_q <= 1'b0;
      if (can_start) begin
        len_q     <= '0;
        hdr_idx_q <= '0;
        cnt_q     <= '0;
        csum_q    <= '0;
      end else if (acc) begin
        case (state_q)
          ST_HDR: begin
            len_q     <= hdr_len;
            hdr_idx_q <= hdr_idx_q + 2'd1;
          end
          ST_LOAD: begin
            we_q    <= 1'b1;
            waddr_q <= BASE_ADDR + ADDR_WIDTH'(cnt_q);
            wdata_q <= byte_i;
            csum_q  <= csum_q ^ byte_i;
            cnt_q   <= cnt_nxt;
          end
          default: ;
        endcase
      end
    end
  end

  assign we_o    = we_q;
  assign waddr_o = waddr_q;
  assign wdata_o = wdata_q;

endmodule

// File: tb/tb_instrmem_loader.sv
// Self-checking bench for instrmem_loader: table-driven frames, random frames
// against a frame-level reference model, and hand-written corner sequences.
module tb_instrmem_loader;
  import instrmem_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        start_i = 1'b0;
  logic [7:0]  byte_i = 8'h00;
  logic        byte_valid_i = 1'b0;
  logic        byte_ready_o, we_o, busy_o, done_o, err_o, cpu_rst_o;
  logic [31:0] waddr_o;
  logic [7:0]  wdata_o;

  instrmem_loader dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .byte_i(byte_i),
    .byte_valid_i(byte_valid_i), .byte_ready_o(byte_ready_o), .we_o(we_o),
    .waddr_o(waddr_o), .wdata_o(wdata_o), .busy_o(busy_o), .done_o(done_o),
    .err_o(err_o), .cpu_rst_o(cpu_rst_o)
  );

  always #5 clk_i = ~clk_i;

  int          checks = 0;
  int          failures = 0;
  int          nwr = 0;
  logic [31:0] last_waddr = 32'h0;
  logic [7:0]  mem [4096];
  logic [7:0]  pay [4096];

  // Memory model: every observed write strobe lands here.
  always @(negedge clk_i) begin : mon
    logic [31:0] off;
    if (we_o) begin
      nwr++;
      last_waddr = waddr_o;
      off = waddr_o - BASE_ADDR;
      if (off < 32'd4096) mem[off[11:0]] = wdata_o;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Offer one byte (optionally after a random idle gap) and wait for acceptance.
  task automatic send_byte(input logic [7:0] b, input bit gaps, output int cyc, output bit to);
    bit r;
    if (gaps && $urandom_range(1, 0) == 1) begin
      byte_valid_i = 1'b0;
      repeat ($urandom_range(3, 1)) @(posedge clk_i);
      #1;
    end
    byte_i = b;
    byte_valid_i = 1'b1;
    cyc = 0;
    to = 1'b0;
    while (1) begin
      r = byte_ready_o;
      @(posedge clk_i); #1;
      cyc++;
      if (r) break;
      if (cyc > 200) begin
        to = 1'b1;
        checks++;
        failures++;
        $display("FAIL accept_timeout: byte %0h not accepted within 200 cycles", b);
        break;
      end
    end
  endtask

  // Drive one complete frame; payload comes from pay[]. Returns the status
  // sampled the cycle after the final accepted byte, and the write count.
  task automatic run_frame(input logic [31:0] len, input logic [7:0] cs, input bit gaps,
                           input string tag, output logic d, output logic e,
                           output logic cr, output logic rdy, output int nw);
    int w0, cyc, n;
    bit to, bad;
    bad = 1'b0;
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    chk({tag, "_busy_on_start"}, 32'(busy_o), 32'd1);
    chk({tag, "_ready_on_start"}, 32'(byte_ready_o), 32'd1);
    w0 = nwr;
    for (int i = 0; i < 4 && !bad; i++) begin
      send_byte(len[8*i +: 8], gaps, cyc, to);
      bad = to;
    end
    if (!bad && !err_o) begin
      n = (len > 32'd4096) ? 4096 : int'(len);
      for (int i = 0; i < n && !bad; i++) begin
        send_byte(pay[i], gaps, cyc, to);
        bad = to;
        if (!bad) begin
          chk({tag, "_we"}, 32'(we_o), 32'd1);
          chk({tag, "_waddr"}, waddr_o, BASE_ADDR + 32'(i));
          chk({tag, "_wdata"}, 32'(wdata_o), 32'(pay[i]));
          if (!gaps) chk({tag, "_cycles_per_byte"}, 32'(cyc), 32'd1);
        end
      end
      if (!bad) begin
        send_byte(cs, gaps, cyc, to);
        bad = to;
      end
    end
    byte_valid_i = 1'b0;
    d = done_o; e = err_o; cr = cpu_rst_o; rdy = byte_ready_o;
    if (!bad) chk({tag, "_busy_at_end"}, 32'(busy_o), 32'd0);
    repeat (2) @(posedge clk_i);
    #1;
    nw = nwr - w0;
  endtask

  // Frame-level reference: XOR of payload, oversize rejection, write count.
  task automatic model(input logic [31:0] len, input logic [7:0] cs,
                       output logic d, output logic e, output int nw);
    logic [7:0] x;
    x = 8'h00;
    if (len > 32'(MEM_BYTES)) begin
      d = 1'b0; e = 1'b1; nw = 0;
    end else begin
      for (int i = 0; i < int'(len); i++) x ^= pay[i];
      d = (x == cs); e = (x != cs); nw = int'(len);
    end
  endtask

  typedef struct {
    logic [31:0] len;
    logic [63:0] pl;
    logic [7:0]  cs;
    logic        d;
    logic        e;
    int          nw;
  } vec_t;

  vec_t tbl [9];

  initial begin : main
    logic d, e, cr, rdy, md, me;
    int nw, mnw, w0, cyc, mism;
    bit to;
    logic [31:0] len;
    logic [7:0] cs, x;

    tbl[0] = '{32'd4,          64'h0000_0000_0000_0013, 8'h13, 1'b1, 1'b0, 4};
    tbl[1] = '{32'd4,          64'h0000_0000_0000_0013, 8'h12, 1'b0, 1'b1, 4};
    tbl[2] = '{32'h0000_1001,  64'h0,                   8'h00, 1'b0, 1'b1, 0};
    tbl[3] = '{32'd0,          64'h0,                   8'h00, 1'b1, 1'b0, 0};
    tbl[4] = '{32'd0,          64'h0,                   8'h5A, 1'b0, 1'b1, 0};
    tbl[5] = '{32'd3,          64'h0000_0000_0030_2010, 8'h00, 1'b1, 1'b0, 3};
    tbl[6] = '{32'd8,          64'h0102_0408_1020_4080, 8'hFF, 1'b1, 1'b0, 8};
    tbl[7] = '{32'hFFFF_FFFF,  64'h0,                   8'h00, 1'b0, 1'b1, 0};
    tbl[8] = '{32'd1,          64'h0000_0000_0000_00AA, 8'hAB, 1'b0, 1'b1, 1};

    // Async reset before the first clock edge.
    rst_ni = 1'b1;
    #1 rst_ni = 1'b0;
    #2;
    chk("rst_ready", 32'(byte_ready_o), 32'd0);
    chk("rst_we", 32'(we_o), 32'd0);
    chk("rst_waddr", waddr_o, 32'hBFC0_0000);
    chk("rst_wdata", 32'(wdata_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_cpu_rst", 32'(cpu_rst_o), 32'd1);
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // Table-driven frames, valid held high.
    for (int t = 0; t < 9; t++) begin
      for (int i = 0; i < 8; i++) pay[i] = tbl[t].pl[8*i +: 8];
      run_frame(tbl[t].len, tbl[t].cs, 1'b0, $sformatf("tbl%0d", t), d, e, cr, rdy, nw);
      chk($sformatf("tbl%0d_done", t), 32'(d), 32'(tbl[t].d));
      chk($sformatf("tbl%0d_err", t), 32'(e), 32'(tbl[t].e));
      chk($sformatf("tbl%0d_cpu_rst", t), 32'(cr), 32'(!tbl[t].d));
      chk($sformatf("tbl%0d_ready_after", t), 32'(rdy), 32'd0);
      chk($sformatf("tbl%0d_writes", t), 32'(nw), 32'(tbl[t].nw));
    end

    // Random frames with random valid gaps, checked against the model.
    for (int r = 0; r < 12; r++) begin
      len = 32'($urandom_range(40, 0));
      if ($urandom_range(5, 0) == 0) len = 32'd4097 + 32'($urandom_range(100000, 0));
      x = 8'h00;
      for (int i = 0; i < 41; i++) pay[i] = 8'($urandom);
      for (int i = 0; i < 41 && i < int'(len); i++) x ^= pay[i];
      cs = ($urandom_range(1, 0) == 1) ? x : (x ^ 8'($urandom_range(255, 1)));
      model(len, cs, md, me, mnw);
      run_frame(len, cs, 1'b1, $sformatf("rnd%0d", r), d, e, cr, rdy, nw);
      chk($sformatf("rnd%0d_done", r), 32'(d), 32'(md));
      chk($sformatf("rnd%0d_err", r), 32'(e), 32'(me));
      chk($sformatf("rnd%0d_writes", r), 32'(nw), 32'(mnw));
    end

    // Full-capacity random load.
    for (int i = 0; i < 4096; i++) begin
      pay[i] = 8'($urandom);
      mem[i] = ~pay[i];
    end
    x = 8'h00;
    for (int i = 0; i < 4096; i++) x ^= pay[i];
    model(32'd4096, x, md, me, mnw);
    run_frame(32'd4096, x, 1'b1, "full", d, e, cr, rdy, nw);
    chk("full_done", 32'(d), 32'(md));
    chk("full_cpu_rst", 32'(cr), 32'd0);
    chk("full_writes", 32'(nw), 32'(mnw));
    chk("full_last_addr", last_waddr, 32'hBFC0_0FFF);
    mism = 0;
    for (int i = 0; i < 4096; i++) if (mem[i] !== pay[i]) mism++;
    chk("full_mem_match", 32'(mism), 32'd0);

    // Length 0 then start in DONE clears done and re-enters the header phase.
    run_frame(32'd0, 8'h00, 1'b0, "zero", d, e, cr, rdy, nw);
    chk("zero_done", 32'(d), 32'd1);
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    chk("restart_done_clr", 32'(done_o), 32'd0);
    chk("restart_busy", 32'(busy_o), 32'd1);
    chk("restart_cpu_rst", 32'(cpu_rst_o), 32'd1);
    // Finish this frame: len 4, start pulsed mid-payload must be ignored.
    for (int i = 0; i < 4; i++) pay[i] = 8'($urandom);
    w0 = nwr;
    send_byte(8'h04, 1'b0, cyc, to);
    send_byte(8'h00, 1'b0, cyc, to);
    send_byte(8'h00, 1'b0, cyc, to);
    send_byte(8'h00, 1'b0, cyc, to);
    send_byte(pay[0], 1'b0, cyc, to);
    send_byte(pay[1], 1'b0, cyc, to);
    start_i = 1'b1;
    send_byte(pay[2], 1'b0, cyc, to);
    start_i = 1'b0;
    chk("busy_start_waddr", waddr_o, 32'hBFC0_0002);
    send_byte(pay[3], 1'b0, cyc, to);
    send_byte(pay[0] ^ pay[1] ^ pay[2] ^ pay[3], 1'b0, cyc, to);
    byte_valid_i = 1'b0;
    chk("busy_start_done", 32'(done_o), 32'd1);
    repeat (2) @(posedge clk_i); #1;
    chk("busy_start_writes", 32'(nwr - w0), 32'd4);
    chk("busy_start_last_addr", last_waddr, 32'hBFC0_0003);

    // Reset mid-LOAD after 2 of 8 payload bytes.
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    send_byte(8'h08, 1'b0, cyc, to);
    send_byte(8'h00, 1'b0, cyc, to);
    send_byte(8'h00, 1'b0, cyc, to);
    send_byte(8'h00, 1'b0, cyc, to);
    send_byte(8'hAA, 1'b0, cyc, to);
    send_byte(8'hBB, 1'b0, cyc, to);
    chk("midrst_we_pending", 32'(we_o), 32'd1);
    w0 = nwr;
    #1 rst_ni = 1'b0;
    #1;
    chk("midrst_we", 32'(we_o), 32'd0);
    chk("midrst_ready", 32'(byte_ready_o), 32'd0);
    chk("midrst_busy", 32'(busy_o), 32'd0);
    chk("midrst_waddr", waddr_o, 32'hBFC0_0000);
    chk("midrst_wdata", 32'(wdata_o), 32'd0);
    chk("midrst_cpu_rst", 32'(cpu_rst_o), 32'd1);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    repeat (5) @(posedge clk_i);
    #1;
    chk("midrst_idle_busy", 32'(busy_o), 32'd0);
    chk("midrst_idle_ready", 32'(byte_ready_o), 32'd0);
    chk("midrst_no_writes", 32'(nwr - w0), 32'd0);
    byte_valid_i = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
